// File: rtl/heaa_pkg.sv
// heaa_pkg: shared parameter defaults and FSM state encoding for the error monitor
package heaa_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 48;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/heaa_err_monitor_absdiff.sv
// heaa_absdiff: unsigned absolute difference of two W-bit values
module heaa_absdiff #(
    parameter int W = 33
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] d_o
);
    assign d_o = x_i > y_i ? x_i - y_i : y_i - x_i;
endmodule

// File: rtl/heaa_err_monitor.sv
// heaa_err_monitor: measures error count, max and saturating sum of error distance of an approximate adder
module heaa_err_monitor
    import heaa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH:0]   approx_sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [WIDTH:0]   max_ed_o,
    output logic [ACC_W-1:0] sum_ed_o
);
    localparam int EW = WIDTH + 1;
    localparam int SW = (ACC_W > EW ? ACC_W : EW) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, cnt_q, err_q;
    logic             v1_q;
    logic [WIDTH-1:0] a1_q, b1_q;
    logic [EW-1:0]    ap1_q, max_q, exact, ed;
    logic [ACC_W-1:0] sum_q;
    logic [SW-1:0]    sum_ext;
    logic             accept, clear;

    assign in_ready_o = state_q == S_RUN && cnt_q < n_q;
    assign accept     = in_valid_i & in_ready_o;
    assign clear      = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign exact      = EW'(a1_q) + EW'(b1_q);
    assign sum_ext    = SW'(sum_q) + SW'(ed);

    heaa_absdiff #(.W(EW)) u_absdiff (.x_i(exact), .y_i(ap1_q), .d_o(ed));

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = num_samples_i == '0 ? S_DONE : S_RUN;
        else if (state_q == S_RUN && accept && cnt_q + CNT_W'(1) == n_q)
            state_d = S_DRAIN;
        // nothing enters during DRAIN, so the single pipeline stage empties on this edge
        else if (state_q == S_DRAIN)
            state_d = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            ap1_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            v1_q    <= accept;
            if (accept) begin
                a1_q  <= a_i;
                b1_q  <= b_i;
                ap1_q <= approx_sum_i;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (clear) begin
                n_q   <= num_samples_i;
                cnt_q <= '0;
                err_q <= '0;
                max_q <= '0;
                sum_q <= '0;
            end else if (v1_q) begin
                err_q <= err_q + CNT_W'(ed != '0);
                max_q <= ed > max_q ? ed : max_q;
                sum_q <= |sum_ext[SW-1:ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            end
        end
    end

    assign busy_o      = state_q == S_RUN || state_q == S_DRAIN;
    assign done_o      = state_q == S_DONE;
    assign err_count_o = err_q;
    assign max_ed_o    = max_q;
    assign sum_ed_o    = sum_q;
endmodule
